// File: rtl/systolic_feeder.sv
// systolic_feeder: NxN operand store and diagonally skewed edge-stream generator for a systolic multiplier.
// Define SYSTOLIC_FEEDER_CLR_EN to insert the CLEAR state and the arr_clr pulse ahead of each feed.
module systolic_feeder #(
    parameter int N         = 4,
    parameter int DATA_SIZE = 4,
    parameter int IDX_W     = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [IDX_W-1:0]       wr_row,
    input  logic [IDX_W-1:0]       wr_col,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_clr,
    output logic [N*DATA_SIZE-1:0] a_out,
    output logic [N*DATA_SIZE-1:0] b_out
);
    // state  | meaning
    // IDLE   | accept operand writes, wait for start
    // CLEAR  | arr_clr pulse, lanes zero
    // STREAM | one skew step t per cycle, t = 0 .. 3N-3
    // DONE   | done pulse, PE accumulators hold A x B
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

    localparam int              LAST   = 3 * N - 3;
    localparam int              CW     = $clog2(LAST + 1);
    localparam logic [CW-1:0]   LAST_C = CW'(LAST);

    state_t                      state;
    logic [CW-1:0]               rem;
    logic [CW-1:0]               t_nxt;
    logic                        wr_ok;
    logic signed [DATA_SIZE-1:0] mat_a [N][N];
    logic signed [DATA_SIZE-1:0] mat_b [N][N];
    logic [N*DATA_SIZE-1:0]      a_nxt;
    logic [N*DATA_SIZE-1:0]      b_nxt;

    assign wr_ok = wr_en && (state == IDLE) && !start;

    // rem counts the steps still to go after the current one, so the step index is LAST - rem
    assign t_nxt = (state == STREAM) ? (LAST_C - rem + CW'(1)) : '0;

    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (i + k == int'(t_nxt)) begin
                    a_nxt[i*DATA_SIZE +: DATA_SIZE] = mat_a[i][k];
                    b_nxt[i*DATA_SIZE +: DATA_SIZE] = mat_b[k][i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    mat_a[i][j] <= '0;
                    mat_b[i][j] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (wr_sel)
                mat_b[wr_row][wr_col] <= wr_data;
            else
                mat_a[wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_out <= '0;
            b_out <= '0;
`ifdef SYSTOLIC_FEEDER_CLR_EN
            arr_clr <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            a_out <= '0;
            b_out <= '0;
`ifdef SYSTOLIC_FEEDER_CLR_EN
            arr_clr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef SYSTOLIC_FEEDER_CLR_EN
                        state   <= CLEAR;
                        arr_clr <= 1'b1;
`else
                        state <= STREAM;
                        rem   <= LAST_C;
                        a_out <= a_nxt;
                        b_out <= b_nxt;
`endif
                    end
                end
                CLEAR: begin
                    state <= STREAM;
                    rem   <= LAST_C;
                    a_out <= a_nxt;
                    b_out <= b_nxt;
                end
                STREAM: begin
                    if (rem == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rem   <= rem - CW'(1);
                        a_out <= a_nxt;
                        b_out <= b_nxt;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYSTOLIC_FEEDER_CLR_EN
    assign arr_clr = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed testbench for systolic_feeder with a behavioural 4x4 signed PE array on its edges.
// Latency expectations follow SYSTOLIC_FEEDER_CLR_EN when it is defined for the build.
module tb_systolic_feeder;
    localparam int N         = 4;
    localparam int DATA_SIZE = 4;
    localparam int IDX_W     = 2;
`ifdef SYSTOLIC_FEEDER_CLR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif
    localparam int S0    = 1 + CLR;
    localparam int SL    = S0 + 3 * N - 3;
    localparam int DC    = SL + 1;
    localparam int STEPS = 3 * N - 2;

    logic                   clk;
    logic                   reset;
    logic                   wr_en;
    logic                   wr_sel;
    logic [IDX_W-1:0]       wr_row;
    logic [IDX_W-1:0]       wr_col;
    logic [DATA_SIZE-1:0]   wr_data;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   arr_clr;
    logic [N*DATA_SIZE-1:0] a_out;
    logic [N*DATA_SIZE-1:0] b_out;

    int errors = 0;
    int checks = 0;
    logic pe_clr;
    logic [N*DATA_SIZE-1:0] a_seen [STEPS];
    logic [N*DATA_SIZE-1:0] b_seen [STEPS];

    systolic_feeder #(.N(N), .DATA_SIZE(DATA_SIZE), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .arr_clr(arr_clr), .a_out(a_out), .b_out(b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer array: a moves right, b moves down, each PE accumulates a*b.
    logic signed [15:0] pa [N][N];
    logic signed [15:0] pb [N][N];
    logic signed [15:0] acc [N][N];
    logic signed [15:0] pa_in [N][N];
    logic signed [15:0] pb_in [N][N];

    function automatic logic signed [15:0] sx(input logic [DATA_SIZE-1:0] v);
        return {{(16-DATA_SIZE){v[DATA_SIZE-1]}}, v};
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pa_in[i][j] = '0;
                pb_in[i][j] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            pa_in[i][0] = sx(a_out[i*DATA_SIZE +: DATA_SIZE]);
            pb_in[0][i] = sx(b_out[i*DATA_SIZE +: DATA_SIZE]);
            for (int j = 1; j < N; j++) begin
                pa_in[i][j] = pa[i][j-1];
                pb_in[j][i] = pb[j-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (reset || arr_clr || pe_clr) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= pa_in[i][j];
                    pb[i][j]  <= pb_in[i][j];
                    acc[i][j] <= acc[i][j] + pa_in[i][j] * pb_in[i][j];
                end
            end
        end
    end

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IDX_W'(r);
        wr_col  = IDX_W'(c);
        wr_data = DATA_SIZE'(d);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic clear_pes;
        pe_clr = 1'b1;
        step();
        pe_clr = 1'b0;
    endtask

    // One complete feed; checks busy/done/arr_clr and idle lanes every cycle, records stream lanes.
    // With disturb set, start and a write to A[3][3] are driven during step 4.
    task automatic feed(input bit disturb);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= DC + 2; cyc++) begin
            if (cyc >= S0 && cyc <= SL) begin
                a_seen[cyc-S0] = a_out;
                b_seen[cyc-S0] = b_out;
            end else begin
                chkv($sformatf("a_idle@%0d", cyc), 64'(a_out), 64'd0);
                chkv($sformatf("b_idle@%0d", cyc), 64'(b_out), 64'd0);
            end
            chkv($sformatf("busy@%0d", cyc), 64'(busy), 64'(cyc <= SL));
            chkv($sformatf("done@%0d", cyc), 64'(done), 64'(cyc == DC));
            chkv($sformatf("arr_clr@%0d", cyc), 64'(arr_clr), 64'(CLR == 1 && cyc == 1));
            if (disturb && cyc == S0 + 4) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_row  = 2'd3;
                wr_col  = 2'd3;
                wr_data = 4'hF;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int s = 0; s < STEPS; s++) begin
            chkv($sformatf("%s_a%0d", tag, s), 64'(a_seen[s]), 64'd0);
            chkv($sformatf("%s_b%0d", tag, s), 64'(b_seen[s]), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; pe_clr = 1'b0;
        repeat (2) step();
        chkv("rst_busy", 64'(busy), 64'd0);
        chkv("rst_done", 64'(done), 64'd0);
        chkv("rst_clr", 64'(arr_clr), 64'd0);
        chkv("rst_a", 64'(a_out), 64'd0);
        chkv("rst_b", 64'(b_out), 64'd0);
        reset = 1'b0;
        step();

        feed(1'b0);
        chk_all_zero("empty");

        // Skew pattern A[i][k] = 4i+k-8, B[k][j] = k-j
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                wr(1'b0, i, k, 4 * i + k - 8);
                wr(1'b1, i, k, i - k);
            end
        feed(1'b0);
        chkv("s0_a", 64'(a_seen[0]), 64'h0008);
        chkv("s0_b", 64'(b_seen[0]), 64'h0000);
        chkv("s1_a", 64'(a_seen[1]), 64'h00C9);
        chkv("s1_b", 64'(b_seen[1]), 64'h00F1);
        chkv("s3_a", 64'(a_seen[3]), 64'h41EB);
        chkv("s3_b", 64'(b_seen[3]), 64'hDF13);
        chkv("s5_a", 64'(a_seen[5]), 64'h6300);
        chkv("s5_b", 64'(b_seen[5]), 64'hF100);
        chkv("s6_a", 64'(a_seen[6]), 64'h7000);
        chkv("s6_b", 64'(b_seen[6]), 64'h0000);
        for (int s = 7; s < STEPS; s++) begin
            chkv($sformatf("flush_a%0d", s), 64'(a_seen[s]), 64'd0);
            chkv($sformatf("flush_b%0d", s), 64'(b_seen[s]), 64'd0);
        end

        // start and write during STREAM are ignored
        feed(1'b1);
        chkv("dist_s6_a", 64'(a_seen[6]), 64'h7000);
        feed(1'b0);
        chkv("after_s6_a", 64'(a_seen[6]), 64'h7000);
        chkv("after_s3_a", 64'(a_seen[3]), 64'h41EB);

        // End-to-end: A all 7, B all -8
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wr(1'b0, i, j, 7);
                wr(1'b1, i, j, -8);
            end
        clear_pes();
        feed(1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chks($sformatf("c7x-8[%0d][%0d]", i, j), acc[i][j], -224);

        // End-to-end: identity x B, B[k][j] = k-j
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wr(1'b0, i, j, (i == j) ? 1 : 0);
                wr(1'b1, i, j, i - j);
            end
        clear_pes();
        feed(1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chks($sformatf("cIxB[%0d][%0d]", i, j), acc[i][j], i - j);

        // Mid-stream reset at step 5
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (S0 + 4) step();
        chkv("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chkv("abort_busy", 64'(busy), 64'd0);
        chkv("abort_a", 64'(a_out), 64'd0);
        chkv("abort_b", 64'(b_out), 64'd0);
        chkv("abort_done", 64'(done), 64'd0);
        for (int c = 0; c < 3 * N; c++) begin
            step();
            chkv($sformatf("abort_nodone%0d", c), 64'(done), 64'd0);
            chkv($sformatf("abort_idle%0d", c), 64'(busy), 64'd0);
        end
        feed(1'b0);
        chk_all_zero("cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
